// File: rtl/binary_clock_pkg.sv
// Shared types and constants for the settable binary clock.
package binary_clock_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2
   } mode_e;

   localparam int SEC_LIMIT  = 60;
   localparam int MIN_LIMIT  = 60;
   localparam int HR24_LIMIT = 24;
   localparam int HR12_LIMIT = 12;

   localparam int SEC_W = 6;
   localparam int MIN_W = 6;
   localparam int HR_W  = 5;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter covering BASE..BASE+LIMIT-1. i_en is the cascade enable and
// produces a carry when wrapping; i_inc is a manual step that wraps silently.
module mod_counter #(
   parameter int W       = 6,
   parameter int LIMIT   = 60,
   parameter int BASE    = 0,
   parameter int RST_VAL = 0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic         i_inc,
   output logic [W-1:0] o_value,
   output logic         o_carry
);

   localparam logic [W-1:0] MAX_V  = W'(BASE + LIMIT - 1);
   localparam logic [W-1:0] BASE_V = W'(BASE);
   localparam logic [W-1:0] RST_V  = W'(RST_VAL);

   logic [W-1:0] r_value;
   logic         w_at_max;

   assign w_at_max = (r_value == MAX_V);
   assign o_carry  = i_en & w_at_max;
   assign o_value  = r_value;

   // count with wrap on either the cascade enable or a manual step
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_value <= RST_V;
      end else if (i_en || i_inc) begin
         r_value <= w_at_max ? BASE_V : (r_value + {{(W-1){1'b0}}, 1'b1});
      end else begin
         r_value <= r_value;
      end
   end

endmodule

// File: rtl/settable_binary_clock.sv
// Binary clock with button-driven set mode and a row-scanned LED matrix.
module settable_binary_clock
   import binary_clock_pkg::*;
#(
   parameter int DIV      = 100,
   parameter int SCAN_DIV = 1,
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int MODE24   = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_btn_mode,
   input  logic            i_btn_inc,
   output logic [ROWS-1:0] o_rows,
   output logic [COLS-1:0] o_cols,
   output logic            o_sec_tick,
   output logic            o_day_tick
);

   localparam int NPIX     = ROWS * COLS;
   localparam int PIX_W    = (NPIX > 17) ? NPIX : 17;
   localparam int HALF     = (DIV / 2 > 0) ? DIV / 2 : 1;
   localparam int PRE_W    = cnt_width(DIV);
   localparam int BLK_W    = cnt_width(HALF);
   localparam int SCN_W    = cnt_width(SCAN_DIV);
   localparam int ROW_W    = cnt_width(ROWS);
   localparam int HR_LIMIT = (MODE24 != 0) ? HR24_LIMIT : HR12_LIMIT;
   localparam int HR_BASE  = (MODE24 != 0) ? 0 : 1;
   localparam int HR_RST   = (MODE24 != 0) ? 0 : 12;

   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(HALF - 1);
   localparam logic [SCN_W-1:0] SCN_MAX = SCN_W'(SCAN_DIV - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

   mode_e            r_state, w_state_nxt;
   logic             r_mode_prev, r_inc_prev;
   logic             w_mode_rise, w_inc_rise, w_inc_ok;
   logic             w_run, w_set_h, w_set_m, w_leave_set;
   logic [PRE_W-1:0] r_presc;
   logic             w_strobe;
   logic [BLK_W-1:0] r_blink_cnt;
   logic             r_blink;
   logic [SCN_W-1:0] r_scan_cnt;
   logic [ROW_W-1:0] r_row;
   logic [SEC_W-1:0] w_sec;
   logic [MIN_W-1:0] w_min;
   logic [HR_W-1:0]  w_hr;
   logic             w_sec_carry, w_min_carry, w_hr_carry;
   logic [PIX_W-1:0] w_pix;
   logic [COLS-1:0]  w_row_pix;
   logic [ROWS-1:0]  r_rows;
   logic [COLS-1:0]  r_cols;
   logic             r_sec_tick, r_day_tick;

   // Sampling the buttons during reset too means a button held through
   // reset is seen as already high and cannot fake a rising edge.
   always_ff @(posedge i_clk) begin
      r_mode_prev <= i_btn_mode;
      r_inc_prev  <= i_btn_inc;
   end

   assign w_mode_rise = i_btn_mode & ~r_mode_prev;
   assign w_inc_rise  = i_btn_inc & ~r_inc_prev;
   // a mode change in the same cycle swallows the increment
   assign w_inc_ok    = w_inc_rise & ~w_mode_rise;

   // mode state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // mode next-state: each mode press advances RUN -> SET_H -> SET_M -> RUN
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     w_state_nxt = w_mode_rise ? SET_H : RUN;
         SET_H:   w_state_nxt = w_mode_rise ? SET_M : SET_H;
         SET_M:   w_state_nxt = w_mode_rise ? RUN : SET_M;
         default: w_state_nxt = RUN;
      endcase
   end

   // mode decode
   always_comb begin
      w_run   = 1'b0;
      w_set_h = 1'b0;
      w_set_m = 1'b0;
      case (r_state)
         RUN:     w_run   = 1'b1;
         SET_H:   w_set_h = 1'b1;
         SET_M:   w_set_m = 1'b1;
         default: w_run   = 1'b1;
      endcase
   end

   assign w_leave_set = w_set_m & w_mode_rise;

   // seconds prescaler: runs only in RUN, restarts when leaving set mode
   always_ff @(posedge i_clk) begin
      if (i_rst || w_leave_set) begin
         r_presc <= '0;
      end else if (w_run) begin
         r_presc <= (r_presc == PRE_MAX) ? '0 : (r_presc + {{(PRE_W-1){1'b0}}, 1'b1});
      end else begin
         r_presc <= r_presc;
      end
   end

   assign w_strobe = w_run & (r_presc == PRE_MAX);

   mod_counter #(.W(SEC_W), .LIMIT(SEC_LIMIT), .BASE(0), .RST_VAL(0)) u_sec (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (w_leave_set),
      .i_en    (w_strobe),
      .i_inc   (1'b0),
      .o_value (w_sec),
      .o_carry (w_sec_carry)
   );

   mod_counter #(.W(MIN_W), .LIMIT(MIN_LIMIT), .BASE(0), .RST_VAL(0)) u_min (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (1'b0),
      .i_en    (w_sec_carry),
      .i_inc   (w_set_m & w_inc_ok),
      .o_value (w_min),
      .o_carry (w_min_carry)
   );

   mod_counter #(.W(HR_W), .LIMIT(HR_LIMIT), .BASE(HR_BASE), .RST_VAL(HR_RST)) u_hr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (1'b0),
      .i_en    (w_min_carry),
      .i_inc   (w_set_h & w_inc_ok),
      .o_value (w_hr),
      .o_carry (w_hr_carry)
   );

   // free-running blink phase, toggling every half second
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b0;
      end else if (r_blink_cnt == BLK_MAX) begin
         r_blink_cnt <= '0;
         r_blink     <= ~r_blink;
      end else begin
         r_blink_cnt <= r_blink_cnt + {{(BLK_W-1){1'b0}}, 1'b1};
         r_blink     <= r_blink;
      end
   end

   // row scan: step to the next row every SCAN_DIV cycles
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_scan_cnt <= '0;
         r_row      <= '0;
      end else if (r_scan_cnt == SCN_MAX) begin
         r_scan_cnt <= '0;
         r_row      <= (r_row == ROW_MAX) ? '0 : (r_row + {{(ROW_W-1){1'b0}}, 1'b1});
      end else begin
         r_scan_cnt <= r_scan_cnt + {{(SCN_W-1){1'b0}}, 1'b1};
         r_row      <= r_row;
      end
   end

   // pixel map: minutes, hours, then seconds when the matrix is big enough
   always_comb begin
      w_pix = '0;
      if (w_set_m && r_blink) begin
         w_pix[5:0] = '0;
      end else begin
         w_pix[5:0] = w_min;
      end
      if (w_set_h && r_blink) begin
         w_pix[10:6] = '0;
      end else begin
         w_pix[10:6] = w_hr;
      end
      if (NPIX >= 17) begin
         w_pix[16:11] = w_sec;
      end else begin
         w_pix[16:11] = '0;
      end
   end

   assign w_row_pix = w_pix[r_row * COLS +: COLS];

   // registered display drive and tick pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rows     <= '1;
         r_cols     <= '0;
         r_sec_tick <= 1'b0;
         r_day_tick <= 1'b0;
      end else begin
         r_rows     <= ~(ROWS'(1) << r_row);
         r_cols     <= w_row_pix;
         r_sec_tick <= w_strobe;
         r_day_tick <= w_hr_carry;
      end
   end

   assign o_rows     = r_rows;
   assign o_cols     = r_cols;
   assign o_sec_tick = r_sec_tick;
   assign o_day_tick = r_day_tick;

endmodule

// File: tb/tb_settable_binary_clock.sv
// Bench for settable_binary_clock: a 24-hour 4x5 instance (seconds visible)
// and a 12-hour 4x4 instance, each followed by a time-of-day model.
module tb_settable_binary_clock;

   localparam int DIV    = 4;
   localparam int SCAN   = 2;
   localparam int ROWS   = 4;
   localparam int COLS_A = 5;
   localparam int COLS_B = 4;

   typedef struct {
      int h, m, s, mode, presc, n;
      logic pm, pi;
      int erows, ecols, est, edt;
   } model_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] bm  = 2'b11;   // bit0 -> DUT A, bit1 -> DUT B
   logic [1:0] bi  = 2'b00;
   logic [3:0] rows_a, rows_b, cols_b;
   logic [4:0] cols_a;
   logic       st_a, dt_a, st_b, dt_b;

   int tests = 0;
   int fails = 0;
   model_t ma, mb;
   bit mvalid = 1'b0;

   bit cnt_en = 1'b0;
   int cyc = 0;
   int tick_cnt [2];
   int day_cnt [2];
   int last_tick [2];
   int bad_gap [2];
   int bad_day [2];

   logic [3:0] xr [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] xc [4] = '{4'b1001, 4'b0100, 4'b0001, 4'b0000};

   always #5 clk = ~clk;

   settable_binary_clock #(.DIV(DIV), .SCAN_DIV(SCAN), .ROWS(ROWS), .COLS(COLS_A), .MODE24(1)) u_a (
      .i_clk(clk), .i_rst(rst), .i_btn_mode(bm[0]), .i_btn_inc(bi[0]),
      .o_rows(rows_a), .o_cols(cols_a), .o_sec_tick(st_a), .o_day_tick(dt_a));

   settable_binary_clock #(.DIV(DIV), .SCAN_DIV(SCAN), .ROWS(ROWS), .COLS(COLS_B), .MODE24(0)) u_b (
      .i_clk(clk), .i_rst(rst), .i_btn_mode(bm[1]), .i_btn_inc(bi[1]),
      .o_rows(rows_b), .o_cols(cols_b), .o_sec_tick(st_b), .o_day_tick(dt_b));

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pixels(model_t md, int cols_n);
      int p;
      bit blink;
      blink = ((md.n / (DIV / 2)) % 2) == 1;
      p = 0;
      if (!(md.mode == 2 && blink)) p = p | md.m;
      if (!(md.mode == 1 && blink)) p = p | (md.h << 6);
      if (ROWS * cols_n >= 17) p = p | (md.s << 11);
      return p;
   endfunction

   function automatic model_t step(model_t md, logic r, logic bmi, logic bii, int cols_n, bit m24);
      model_t q;
      int row, t, per, k;
      bit strobe, mrise, irise;
      q = md;
      if (r) begin
         q.h = m24 ? 0 : 12; q.m = 0; q.s = 0; q.mode = 0; q.presc = 0; q.n = 0;
         q.pm = bmi; q.pi = bii;
         q.erows = (1 << ROWS) - 1; q.ecols = 0; q.est = 0; q.edt = 0;
         return q;
      end
      row = (q.n / SCAN) % ROWS;
      q.erows = ((1 << ROWS) - 1) & ~(1 << row);
      q.ecols = (pixels(q, cols_n) >> (row * cols_n)) & ((1 << cols_n) - 1);
      strobe = (q.mode == 0) && (q.presc == DIV - 1);
      q.est = strobe ? 1 : 0;
      q.edt = 0;
      if (q.mode == 0) q.presc = (q.presc + 1) % DIV;
      if (strobe) begin
         per = m24 ? 24 : 12;
         k = m24 ? q.h : q.h - 1;
         t = k * 3600 + q.m * 60 + q.s + 1;
         if (t == per * 3600) begin
            t = 0;
            q.edt = 1;
         end
         k = t / 3600; q.m = (t / 60) % 60; q.s = t % 60;
         q.h = m24 ? k : k + 1;
      end
      mrise = bmi && !q.pm;
      irise = bii && !q.pi;
      if (mrise) begin
         if (q.mode == 2) begin
            q.s = 0;
            q.presc = 0;
         end
         q.mode = (q.mode + 1) % 3;
      end else if (irise) begin
         if (q.mode == 1) q.h = m24 ? (q.h + 1) % 24 : (q.h % 12) + 1;
         else if (q.mode == 2) q.m = (q.m + 1) % 60;
      end
      q.pm = bmi; q.pi = bii;
      q.n++;
      return q;
   endfunction

   // advance both models on every active edge
   always @(posedge clk) begin
      ma = step(ma, rst, bm[0], bi[0], COLS_A, 1'b1);
      mb = step(mb, rst, bm[1], bi[1], COLS_B, 1'b0);
      mvalid = 1'b1;
   end

   // compare every registered output against the models, away from the edge
   always @(negedge clk) begin
      if (mvalid) begin
         check("a_rows", int'(rows_a), ma.erows);
         check("a_cols", int'(cols_a), ma.ecols);
         check("a_sec_tick", int'(st_a), ma.est);
         check("a_day_tick", int'(dt_a), ma.edt);
         check("b_rows", int'(rows_b), mb.erows);
         check("b_cols", int'(cols_b), mb.ecols);
         check("b_sec_tick", int'(st_b), mb.est);
         check("b_day_tick", int'(dt_b), mb.edt);
      end
   end

   // pulse bookkeeping inside a measurement window
   always @(negedge clk) begin
      cyc++;
      if (cnt_en) begin
         if (st_a) begin
            if (last_tick[0] >= 0 && cyc - last_tick[0] != DIV) bad_gap[0]++;
            last_tick[0] = cyc; tick_cnt[0]++;
         end
         if (st_b) begin
            if (last_tick[1] >= 0 && cyc - last_tick[1] != DIV) bad_gap[1]++;
            last_tick[1] = cyc; tick_cnt[1]++;
         end
         if (dt_a) begin
            day_cnt[0]++;
            if (!st_a) bad_day[0]++;
         end
         if (dt_b) begin
            day_cnt[1]++;
            if (!st_b) bad_day[1]++;
         end
      end
   end

   task automatic clr_window();
      for (int i = 0; i < 2; i++) begin
         tick_cnt[i] = 0; day_cnt[i] = 0; last_tick[i] = -1; bad_gap[i] = 0; bad_day[i] = 0;
      end
   endtask

   task automatic run_window(input int n);
      clr_window();
      cnt_en = 1'b1;
      repeat (n) @(negedge clk);
      #1 cnt_en = 1'b0;
   endtask

   task automatic press(input logic [1:0] mm, input logic [1:0] ii);
      @(negedge clk);
      bm = mm; bi = ii;
      @(negedge clk);
      bm = 2'b00; bi = 2'b00;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // reset with mode buttons held high throughout
      repeat (3) @(negedge clk);
      check("rst_rows_a", int'(rows_a), 15);
      check("rst_cols_a", int'(cols_a), 0);
      check("rst_rows_b", int'(rows_b), 15);
      check("rst_cols_b", int'(cols_b), 0);
      rst = 1'b0;

      // free run: 240 cycles -> 60 ticks, 4 apart, no day rollover
      fork
         run_window(240);
         begin
            repeat (3) @(negedge clk);
            bm = 2'b00;
         end
      join
      check("run_ticks_a", tick_cnt[0], 60);
      check("run_gap_a", bad_gap[0], 0);
      check("run_ticks_b", tick_cnt[1], 60);
      check("run_days", day_cnt[0] + day_cnt[1], 0);

      // set path: 3 hours, 5 minutes
      do_reset(2);
      press(2'b11, 2'b00);
      repeat (3) press(2'b00, 2'b11);
      press(2'b11, 2'b00);
      repeat (5) press(2'b00, 2'b11);
      press(2'b11, 2'b00);
      // 05:09 with a minute wrap inside SET_M (5 + 64 -> 9, hours untouched)
      press(2'b11, 2'b00);
      repeat (2) press(2'b00, 2'b11);
      press(2'b11, 2'b00);
      repeat (64) press(2'b00, 2'b11);
      press(2'b11, 2'b00);

      // scan pattern of 05:09 on the 4x4 instance
      k = 0;
      while (rows_b != 4'b1110 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("scan_sync", int'(rows_b == 4'b1110), 1);
      for (int r = 0; r < 4; r++) begin
         check("scan_rows", int'(rows_b), int'(xr[r]));
         check("scan_cols", int'(cols_b), int'(xc[r]));
         repeat (2) @(negedge clk);
      end

      // both buttons together in RUN, then back to RUN, then inc in RUN
      press(2'b11, 2'b11);
      repeat (6) @(negedge clk);
      press(2'b11, 2'b00);
      press(2'b11, 2'b00);
      press(2'b00, 2'b11);
      repeat (6) @(negedge clk);

      // day rollover: A to 23:59:00, B to 12:59:00, then one minute of run
      do_reset(2);
      press(2'b11, 2'b00);
      repeat (23) press(2'b00, 2'b01);
      press(2'b11, 2'b00);
      repeat (59) press(2'b00, 2'b11);
      press(2'b11, 2'b00);
      run_window(240);
      check("day_cnt_a", day_cnt[0], 1);
      check("day_cnt_b", day_cnt[1], 1);
      check("day_with_sec", bad_day[0] + bad_day[1], 0);
      check("day_ticks_a", tick_cnt[0], 60);

      // reset in the middle of SET_M after two increments
      press(2'b11, 2'b00);
      press(2'b11, 2'b00);
      repeat (2) press(2'b00, 2'b11);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midset_rows_a", int'(rows_a), 15);
      check("midset_cols_a", int'(cols_a), 0);
      check("midset_cols_b", int'(cols_b), 0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      press(2'b00, 2'b11);
      repeat (12) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
